// File: rtl/ram_bank_param.sv
// Parametrised single-port synchronous RAM bank with a registered read port,
// a zero-fill sweep after every reset, and rejection of accesses made during that sweep.
module ram_bank_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              E,
  input  logic              W,
  input  logic              R,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] OUT,
  output logic              OUT_VALID,
  output logic              BUSY,
  output logic              REJ
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              rej_q, rej_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              access;

  assign access = E & (W | R);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    rej_d   = 1'b0;
    we      = 1'b0;
    waddr   = ADDR;
    wdata   = D;
    case (state_q)
      CLEAR: begin
        // The sweep owns the write port; user accesses only raise REJ.
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        ptr_d = ptr_q + 1'b1;
        rej_d = access;
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        we = E & W;
        // Reads sample the array before this edge's write lands: read-first.
        if (E && R) begin
          out_d = mem_q[ADDR];
          vld_d = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      rej_q   <= rej_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = vld_q;
  assign BUSY      = (state_q == CLEAR);
  assign REJ       = rej_q;

endmodule

// File: tb/tb_ram_bank_param.sv
// Directed bench for ram_bank_param (DATA_W=16, ADDR_W=3): vector table for
// steady-state accesses plus hand-written reset/sweep sequences.
module tb_ram_bank_param;

  logic        CLK = 1'b0;
  logic        RST, E, W, R;
  logic [2:0]  ADDR;
  logic [15:0] D;
  logic [15:0] OUT;
  logic        OUT_VALID, BUSY, REJ;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        e, w, r;
    logic [2:0]  addr;
    logic [15:0] d;
    logic [15:0] eout;
    logic        evld;
  } vec_t;

  vec_t vt[$];

  ram_bank_param #(.DATA_W(16), .ADDR_W(3)) dut (
    .CLK(CLK), .RST(RST), .E(E), .W(W), .R(R), .ADDR(ADDR), .D(D),
    .OUT(OUT), .OUT_VALID(OUT_VALID), .BUSY(BUSY), .REJ(REJ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic r,
                       input logic [2:0] a, input logic [15:0] d);
    E = e; W = w; R = r; ADDR = a; D = d;
  endtask

  task automatic add_vec(input logic e, input logic w, input logic r, input logic [2:0] a,
                         input logic [15:0] d, input logic [15:0] eout, input logic evld);
    vec_t v;
    v.e = e; v.w = w; v.r = r; v.addr = a; v.d = d; v.eout = eout; v.evld = evld;
    vt.push_back(v);
  endtask

  // Counts BUSY cycles starting with the current sample (the one right after a reset edge).
  task automatic count_busy(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 20) begin
      n++;
      step();
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 3'd0, 16'h0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_out", OUT, 16'h0);
    chk("rst_vld", OUT_VALID, 1'b0);
    chk("rst_busy", BUSY, 1'b1);
    chk("rst_rej", REJ, 1'b0);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 3'(i), 16'h0);
      step();
      chk({tag, "_out"}, OUT, 16'h0);
      chk({tag, "_vld"}, OUT_VALID, 1'b1);
    end
  endtask

  initial begin
    int n;

    // Test 1 reads, test 2 write/read-back, tests 3 and 4 in one continuous stream.
    for (int i = 0; i < 8; i++) add_vec(1, 0, 1, 3'(i), 16'h0, 16'h0000, 1);
    for (int i = 0; i < 8; i++) add_vec(1, 1, 0, 3'(i), 16'(i + 1), 16'h0000, 0);
    for (int i = 0; i < 8; i++) add_vec(1, 0, 1, 3'(i), 16'h0, 16'(i + 1), 1);
    add_vec(1, 0, 0, 3'd0, 16'h0, 16'h0008, 0);
    add_vec(1, 1, 1, 3'd3, 16'hBEEF, 16'h0004, 1);
    add_vec(1, 0, 1, 3'd3, 16'h0, 16'hBEEF, 1);
    add_vec(0, 1, 1, 3'd5, 16'hFFFF, 16'hBEEF, 0);
    add_vec(1, 0, 1, 3'd5, 16'h0, 16'h0006, 1);
    add_vec(0, 0, 0, 3'd0, 16'h0, 16'h0006, 0);

    RST = 1'b0;
    drive(0, 0, 0, 3'd0, 16'h0);
    step();

    // Reset and sweep length
    do_reset();
    count_busy(n);
    chk("sweep_len", 32'(n), 32'd8);

    foreach (vt[i]) begin
      drive(vt[i].e, vt[i].w, vt[i].r, vt[i].addr, vt[i].d);
      step();
      chk($sformatf("vec%0d_out", i), OUT, vt[i].eout);
      chk($sformatf("vec%0d_vld", i), OUT_VALID, vt[i].evld);
      chk($sformatf("vec%0d_busy", i), BUSY, 1'b0);
      chk($sformatf("vec%0d_rej", i), REJ, 1'b0);
    end

    // Accesses during the sweep are rejected and never reach memory
    do_reset();
    drive(0, 0, 0, 3'd0, 16'h0);
    step();
    step();
    drive(1, 1, 0, 3'd7, 16'h1234);
    step();
    chk("busy_wr7_rej", REJ, 1'b1);
    chk("busy_wr7_busy", BUSY, 1'b1);
    drive(1, 1, 1, 3'd0, 16'h5555);
    step();
    chk("busy_wr0_rej", REJ, 1'b1);
    chk("busy_wr0_vld", OUT_VALID, 1'b0);
    chk("busy_wr0_out", OUT, 16'h0);
    drive(0, 0, 0, 3'd0, 16'h0);
    step();
    chk("busy_rej_clear", REJ, 1'b0);
    count_busy(n);
    chk("busy_fell", BUSY, 1'b0);
    drive(1, 0, 1, 3'd7, 16'h0);
    step();
    chk("busy_rd7_out", OUT, 16'h0);
    chk("busy_rd7_vld", OUT_VALID, 1'b1);
    drive(1, 0, 1, 3'd0, 16'h0);
    step();
    chk("busy_rd0_out", OUT, 16'h0);

    // Leave a nonzero word in OUT before the mid-sweep reset
    drive(1, 1, 0, 3'd2, 16'hA5A5);
    step();
    drive(1, 0, 1, 3'd2, 16'h0);
    step();
    chk("pre_rst_out", OUT, 16'hA5A5);

    // Reset asserted again on the 5th BUSY cycle restarts the sweep
    do_reset();
    drive(0, 0, 0, 3'd0, 16'h0);
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy", BUSY, 1'b1);
    do_reset();
    count_busy(n);
    chk("mid_sweep_len", 32'(n), 32'd8);
    read_all_zero("mid_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
